// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent clocked SR flip-flops with synchronous reset and a registered s=r=1 flag.
// Build option SR_FLIP_FLOP_TOGGLE_EN: s=r=1 toggles the bit (JK behaviour) and illegal is held at 0.
module sr_flip_flop #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n,
    output logic [WIDTH-1:0] illegal
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] illegal_next;

    always_comb begin
        q_next       = q_reg;
        illegal_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            unique case ({s[i], r[i]})
                2'b00: q_next[i] = q_reg[i];
                2'b01: q_next[i] = 1'b0;
                2'b10: q_next[i] = 1'b1;
                2'b11: begin
`ifdef SR_FLIP_FLOP_TOGGLE_EN
                    q_next[i] = ~q_reg[i];
`else
                    // forbidden pair resolves reset-dominant and is flagged next cycle
                    q_next[i]       = 1'b0;
                    illegal_next[i] = 1'b1;
`endif
                end
                default: q_next[i] = q_reg[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= RST_VAL;
        end else begin
            q_reg <= q_next;
        end
    end

`ifdef SR_FLIP_FLOP_TOGGLE_EN
    assign illegal = '0;
`else
    logic [WIDTH-1:0] illegal_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_reg <= '0;
        end else begin
            illegal_reg <= illegal_next;
        end
    end

    assign illegal = illegal_reg;
`endif

    assign Q   = q_reg;
    assign Q_n = ~q_reg;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Directed self-checking bench for sr_flip_flop: a WIDTH=1 instance and a WIDTH=4 instance with non-zero reset value.
module tb_sr_flip_flop;

    logic       clk = 1'b0;
    logic       rst;
    logic       s1, r1;
    logic       q1, qn1, ill1;
    logic [3:0] s4, r4;
    logic [3:0] q4, qn4, ill4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sr_flip_flop u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .s       (s1),
        .r       (r1),
        .Q       (q1),
        .Q_n     (qn1),
        .illegal (ill1)
    );

    sr_flip_flop #(.WIDTH(4), .RST_VAL(4'b0110)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .s       (s4),
        .r       (r4),
        .Q       (q4),
        .Q_n     (qn4),
        .illegal (ill4)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected illegal pulse / value after s=r=1 for the active build
`ifdef SR_FLIP_FLOP_TOGGLE_EN
    localparam bit TOGGLE = 1'b1;
`else
    localparam bit TOGGLE = 1'b0;
`endif

    task automatic check1(input string tag, input logic q_exp, input logic ill_exp);
        check({tag, ".Q"},   {3'b0, q1},   {3'b0, q_exp});
        check({tag, ".Q_n"}, {3'b0, qn1},  {3'b0, ~q_exp});
        check({tag, ".ill"}, {3'b0, ill1}, {3'b0, ill_exp});
    endtask

    task automatic check4(input string tag, input logic [3:0] q_exp, input logic [3:0] ill_exp);
        check({tag, ".Q4"},   q4,   q_exp);
        check({tag, ".Q4_n"}, qn4,  ~q_exp);
        check({tag, ".ill4"}, ill4, ill_exp);
    endtask

    initial begin
        rst = 1'b1; s1 = 1'b0; r1 = 1'b0; s4 = 4'b0; r4 = 4'b0;
        tick();
        check1("rst_idle", 1'b0, 1'b0);
        check4("rst_idle", 4'b0110, 4'b0000);

        s1 = 1'b1; s4 = 4'b1111;
        tick();
        check1("rst_prio", 1'b0, 1'b0);
        check4("rst_prio", 4'b0110, 4'b0000);

        rst = 1'b0; s1 = 1'b0; r1 = 1'b1; s4 = 4'b0; r4 = 4'b0;
        tick();
        check1("clear", 1'b0, 1'b0);
        check4("hold_rstval", 4'b0110, 4'b0000);

        s1 = 1'b1; r1 = 1'b0;
        tick();
        check1("set", 1'b1, 1'b0);

        s1 = 1'b0; r1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("hold", 1'b1, 1'b0);
        end

        // input pulse between edges must not be captured
        #2 s1 = 1'b0; r1 = 1'b1;
        #2 s1 = 1'b0; r1 = 1'b0;
        tick();
        check1("glitch", 1'b1, 1'b0);

        s1 = 1'b1; r1 = 1'b1;
        tick();
        check1("forbid_from1", 1'b0, ~TOGGLE);

        s1 = 1'b0; r1 = 1'b0;
        tick();
        check1("after_forbid", 1'b0, 1'b0);

        s1 = 1'b1; r1 = 1'b1;
        tick();
        check1("forbid_run0", TOGGLE ? 1'b1 : 1'b0, ~TOGGLE);
        tick();
        check1("forbid_run1", 1'b0, ~TOGGLE);
        tick();
        check1("forbid_run2", TOGGLE ? 1'b1 : 1'b0, ~TOGGLE);

        s1 = 1'b0; r1 = 1'b1;
        tick();
        check1("clear2", 1'b0, 1'b0);

        // mid-operation reset
        s1 = 1'b1; r1 = 1'b0;
        tick();
        check1("pre_midrst", 1'b1, 1'b0);
        s1 = 1'b1; r1 = 1'b1;
        tick();
        check1("pre_midrst_forbid", TOGGLE ? 1'b0 : 1'b0, ~TOGGLE);
        rst = 1'b1; s1 = 1'b1; r1 = 1'b0; s4 = 4'b1001; r4 = 4'b0110;
        tick();
        check1("midrst", 1'b0, 1'b0);
        check4("midrst", 4'b0110, 4'b0000);
        rst = 1'b0; s4 = 4'b0; r4 = 4'b0;
        tick();
        check1("post_midrst", 1'b1, 1'b0);

        // WIDTH=4: load 1010, then mixed per-bit commands
        s4 = 4'b1010; r4 = 4'b0101;
        tick();
        check4("load", 4'b1010, 4'b0000);

        s4 = 4'b0101; r4 = 4'b0011;
        tick();
        check4("mixed", TOGGLE ? 4'b1101 : 4'b1100, TOGGLE ? 4'b0000 : 4'b0001);

        s4 = 4'b1111; r4 = 4'b1111;
        tick();
        check4("all_forbid", TOGGLE ? 4'b0010 : 4'b0000, TOGGLE ? 4'b0000 : 4'b1111);

        s4 = 4'b0000; r4 = 4'b0000;
        tick();
        check4("all_hold", TOGGLE ? 4'b0010 : 4'b0000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
